pueo_command_decoder_fifo: RTL and testbench

Parametrised successor to the SYSCLK command decoder. It splits the 32-bit command word into:
- trigger strobes;
- run-control pulses;
- a buffered, backpressured mode1 byte stream to the command processor;
- a separate buffered firmware-upgrade stream with an in-band mark.

It sits directly behind the command-link receiver in the `sysclk_i` domain. It replaces the unbuffered decoder whose tready inputs were ignored.

---
 rtl/pueo_command_pkg.sv | 37 +++
 rtl/pueo_cmd_fifo.sv | 65 ++++++
 rtl/pueo_command_decoder_fifo.sv | 198 +++++++++++++++++++
 tb/tb_pueo_command_decoder_fifo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pueo_command_pkg.sv
// Shared field offsets, command codes and the mode1type enum for the
// PUEO command decoder.
package pueo_command_pkg;

    localparam int MSG_BIT       = 31;
    localparam int RUNCMD_LSB    = 26;
    localparam int MODE1TYPE_LSB = 24;
    localparam int MODE1DATA_LSB = 16;
    localparam int TRIG_BIT      = 15;

    localparam logic [1:0] RUNCMD_NOP     = 2'b00;
    localparam logic [1:0] RUNCMD_DO_SYNC = 2'b01;
    localparam logic [1:0] RUNCMD_RESET   = 2'b10;
    localparam logic [1:0] RUNCMD_STOP    = 2'b11;

    localparam logic [1:0] MODE1_SPECIAL = 2'b00;
    localparam logic [1:0] MODE1_NORMAL  = 2'b01;
    localparam logic [1:0] MODE1_FW      = 2'b10;
    localparam logic [1:0] MODE1_LAST    = 2'b11;

    localparam logic [7:0] SPECIAL_CMDPROC_RST = 8'h01;
    localparam logic [7:0] SPECIAL_FW_MARK     = 8'h02;

    localparam logic [15:0] OVF_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        M1_SPECIAL = MODE1_SPECIAL,
        M1_NORMAL  = MODE1_NORMAL,
        M1_FW      = MODE1_FW,
        M1_LAST    = MODE1_LAST
    } mode1type_t;

    function automatic mode1type_t get_mode1type(input logic [31:0] word);
        return mode1type_t'(word[MODE1TYPE_LSB +: 2]);
    endfunction

endpackage

// File: rtl/pueo_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; a push into a full
// FIFO is still accepted when a pop happens on the same edge.
module pueo_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_pop_ok;
    logic             w_push_ok;

    // Status flags, handshake qualification and head-of-queue read
    always_comb begin
        o_empty   = (r_wr_ptr == r_rd_ptr);
        o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
        w_pop_ok  = i_pop & ~o_empty;
        w_push_ok = i_push & ~i_flush & (~o_full | w_pop_ok);
        if (o_empty) begin
            o_rdata = {WIDTH{1'b0}};
        end else begin
            o_rdata = r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    // Pointer update; flush outranks any pop on the same edge
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/pueo_command_decoder_fifo.sv
// Command-word decoder with buffered mode1 and firmware streams.
// Optional overflow counters: define PUEO_CMDDEC_OVF_COUNT_EN.
module pueo_command_decoder_fifo
    import pueo_command_pkg::*;
#(
    parameter int TRIG_TIME_BITS = 15,
    parameter int CMD_FIFO_DEPTH = 16,
    parameter int FW_FIFO_DEPTH  = 16
) (
    input  logic                      sysclk_i,
    input  logic                      sysclk_rst_i,
    input  logic [31:0]               command_i,
    input  logic                      command_valid_i,
    output logic [TRIG_TIME_BITS-1:0] trig_time_o,
    output logic                      trig_valid_o,
    output logic                      rundosync_o,
    output logic                      runrst_o,
    output logic                      runstop_o,
    output logic                      cmdproc_rst_o,
    output logic [7:0]                cmdproc_tdata,
    output logic                      cmdproc_tvalid,
    output logic                      cmdproc_tlast,
    input  logic                      cmdproc_tready,
    output logic [7:0]                fw_tdata,
    output logic                      fw_tuser,
    output logic                      fw_tvalid,
    input  logic                      fw_tready,
    output logic                      fw_mark_o,
    output logic [15:0]               cmd_ovf_count_o,
    output logic [15:0]               fw_ovf_count_o
);
    logic       w_msg;
    mode1type_t w_m1type;
    logic [1:0] w_runcmd;
    logic [7:0] w_m1data;
    logic       w_cmd_push;
    logic [8:0] w_cmd_wdata;
    logic       w_cmd_flush;
    logic       w_fw_push;
    logic [8:0] w_fw_wdata;
    logic [8:0] w_cmd_rdata;
    logic [8:0] w_fw_rdata;
    logic       w_cmd_full;
    logic       w_cmd_empty;
    logic       w_fw_full;
    logic       w_fw_empty;
    logic       w_cmd_drop;
    logic       w_fw_drop;
    logic       r_dosync;
    logic       r_runrst;
    logic       r_runstop;
    logic       r_cmdproc_rst;
    logic       r_fw_mark;
    logic       w_unused;

    // Trigger path is combinational and ignores the message flag
    always_comb begin
        if (sysclk_rst_i) begin
            trig_valid_o = 1'b0;
            trig_time_o  = {TRIG_TIME_BITS{1'b0}};
        end else begin
            trig_valid_o = command_i[TRIG_BIT] & command_valid_i;
            trig_time_o  = command_i[TRIG_TIME_BITS-1:0];
        end
    end

    // Message decode into FIFO pushes and the mode1 flush
    always_comb begin
        w_msg       = ~command_i[MSG_BIT] & command_valid_i & ~sysclk_rst_i;
        w_m1type    = get_mode1type(command_i);
        w_runcmd    = command_i[RUNCMD_LSB +: 2];
        w_m1data    = command_i[MODE1DATA_LSB +: 8];
        w_cmd_push  = 1'b0;
        w_cmd_wdata = 9'h000;
        w_cmd_flush = 1'b0;
        w_fw_push   = 1'b0;
        w_fw_wdata  = 9'h000;
        if (w_msg) begin
            case (w_m1type)
                M1_NORMAL: begin
                    w_cmd_push  = 1'b1;
                    w_cmd_wdata = {1'b0, w_m1data};
                end
                M1_LAST: begin
                    w_cmd_push  = 1'b1;
                    w_cmd_wdata = {1'b1, w_m1data};
                end
                M1_FW: begin
                    w_fw_push  = 1'b1;
                    w_fw_wdata = {1'b0, w_m1data};
                end
                M1_SPECIAL: begin
                    if (w_m1data == SPECIAL_CMDPROC_RST) begin
                        w_cmd_flush = 1'b1;
                    end else if (w_m1data == SPECIAL_FW_MARK) begin
                        w_fw_push  = 1'b1;
                        w_fw_wdata = {1'b1, 8'h00};
                    end else begin
                        w_fw_push = 1'b0;
                    end
                end
                default: begin
                    w_cmd_push = 1'b0;
                end
            endcase
        end else begin
            w_cmd_push = 1'b0;
        end
    end

    pueo_cmd_fifo #(.WIDTH(9), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
        .i_clk   (sysclk_i),
        .i_rst   (sysclk_rst_i),
        .i_flush (w_cmd_flush),
        .i_push  (w_cmd_push),
        .i_wdata (w_cmd_wdata),
        .i_pop   (cmdproc_tready),
        .o_rdata (w_cmd_rdata),
        .o_full  (w_cmd_full),
        .o_empty (w_cmd_empty)
    );

    pueo_cmd_fifo #(.WIDTH(9), .DEPTH(FW_FIFO_DEPTH)) u_fw_fifo (
        .i_clk   (sysclk_i),
        .i_rst   (sysclk_rst_i),
        .i_flush (1'b0),
        .i_push  (w_fw_push),
        .i_wdata (w_fw_wdata),
        .i_pop   (fw_tready),
        .o_rdata (w_fw_rdata),
        .o_full  (w_fw_full),
        .o_empty (w_fw_empty)
    );

    assign cmdproc_tvalid = ~w_cmd_empty;
    assign cmdproc_tdata  = w_cmd_rdata[7:0];
    assign cmdproc_tlast  = w_cmd_rdata[8];
    assign fw_tvalid      = ~w_fw_empty;
    assign fw_tdata       = w_fw_rdata[7:0];
    assign fw_tuser       = w_fw_rdata[8];

    // A full FIFO still takes a byte when its head leaves on the same edge
    assign w_cmd_drop = w_cmd_push & w_cmd_full & ~(cmdproc_tready & ~w_cmd_empty);
    assign w_fw_drop  = w_fw_push & w_fw_full & ~(fw_tready & ~w_fw_empty);

    // Registered run-control, processor-reset and mark pulses
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            r_dosync      <= 1'b0;
            r_runrst      <= 1'b0;
            r_runstop     <= 1'b0;
            r_cmdproc_rst <= 1'b0;
            r_fw_mark     <= 1'b0;
        end else begin
            r_dosync      <= w_msg & (w_runcmd == RUNCMD_DO_SYNC);
            r_runrst      <= w_msg & (w_runcmd == RUNCMD_RESET);
            r_runstop     <= w_msg & (w_runcmd == RUNCMD_STOP);
            r_cmdproc_rst <= w_cmd_flush;
            r_fw_mark     <= ~w_fw_empty & fw_tready & w_fw_rdata[8];
        end
    end

    assign rundosync_o   = r_dosync;
    assign runrst_o      = r_runrst;
    assign runstop_o     = r_runstop;
    assign cmdproc_rst_o = r_cmdproc_rst;
    assign fw_mark_o     = r_fw_mark;

`ifdef PUEO_CMDDEC_OVF_COUNT_EN
    logic [15:0] r_cmd_ovf;
    logic [15:0] r_fw_ovf;

    // Saturating dropped-byte counters; the mode1 flush leaves them alone
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            r_cmd_ovf <= 16'h0000;
            r_fw_ovf  <= 16'h0000;
        end else begin
            if (w_cmd_drop && (r_cmd_ovf != OVF_MAX)) begin
                r_cmd_ovf <= r_cmd_ovf + 16'h0001;
            end
            if (w_fw_drop && (r_fw_ovf != OVF_MAX)) begin
                r_fw_ovf <= r_fw_ovf + 16'h0001;
            end
        end
    end

    assign cmd_ovf_count_o = r_cmd_ovf;
    assign fw_ovf_count_o  = r_fw_ovf;
    assign w_unused        = ^{command_i[30:28], command_i[14:0], w_runcmd == RUNCMD_NOP};
`else
    assign cmd_ovf_count_o = 16'h0000;
    assign fw_ovf_count_o  = 16'h0000;
    assign w_unused        = ^{command_i[30:28], command_i[14:0], w_runcmd == RUNCMD_NOP,
                               w_cmd_drop, w_fw_drop, OVF_MAX};
`endif

endmodule

// File: tb/tb_pueo_command_decoder_fifo.sv
// Directed self-checking bench for pueo_command_decoder_fifo.
module tb_pueo_command_decoder_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] command;
    logic        command_valid;
    logic [14:0] trig_time;
    logic        trig_valid;
    logic        rundosync, runrst, runstop, cmdproc_rst;
    logic [7:0]  cmd_tdata;
    logic        cmd_tvalid, cmd_tlast, cmd_tready;
    logic [7:0]  fw_tdata;
    logic        fw_tuser, fw_tvalid, fw_tready, fw_mark;
    logic [15:0] cmd_ovf, fw_ovf;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_ovf;

    always #5 clk = ~clk;

    pueo_command_decoder_fifo dut (
        .sysclk_i        (clk),
        .sysclk_rst_i    (rst),
        .command_i       (command),
        .command_valid_i (command_valid),
        .trig_time_o     (trig_time),
        .trig_valid_o    (trig_valid),
        .rundosync_o     (rundosync),
        .runrst_o        (runrst),
        .runstop_o       (runstop),
        .cmdproc_rst_o   (cmdproc_rst),
        .cmdproc_tdata   (cmd_tdata),
        .cmdproc_tvalid  (cmd_tvalid),
        .cmdproc_tlast   (cmd_tlast),
        .cmdproc_tready  (cmd_tready),
        .fw_tdata        (fw_tdata),
        .fw_tuser        (fw_tuser),
        .fw_tvalid       (fw_tvalid),
        .fw_tready       (fw_tready),
        .fw_mark_o       (fw_mark),
        .cmd_ovf_count_o (cmd_ovf),
        .fw_ovf_count_o  (fw_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        command       = w;
        command_valid = 1'b1;
        tick();
        command_valid = 1'b0;
        command       = 32'h0000_0000;
    endtask

    initial begin
`ifdef PUEO_CMDDEC_OVF_COUNT_EN
        exp_ovf = 16'd4;
`else
        exp_ovf = 16'd0;
`endif
        rst = 1'b1; command = 32'h0100_8123; command_valid = 1'b1;
        cmd_tready = 1'b0; fw_tready = 1'b0;
        #1;
        chk("rst_trig_valid", {31'd0, trig_valid}, 32'd0);
        chk("rst_trig_time", {17'd0, trig_time}, 32'd0);
        tick(); tick();
        chk("rst_cmd_tvalid", {31'd0, cmd_tvalid}, 32'd0);
        chk("rst_fw_tvalid", {31'd0, fw_tvalid}, 32'd0);
        chk("rst_pulses", {27'd0, rundosync, runrst, runstop, cmdproc_rst, fw_mark}, 32'd0);
        chk("rst_counters", {cmd_ovf, fw_ovf}, 32'd0);
        rst = 1'b0; command_valid = 1'b0; command = 32'h0;
        tick();

        // trigger + NORMAL 0x00
        command = 32'h0100_8123; command_valid = 1'b1;
        #1;
        chk("trig_valid", {31'd0, trig_valid}, 32'd1);
        chk("trig_time", {17'd0, trig_time}, 32'h0123);
        tick();
        command_valid = 1'b0; command = 32'h0;
        chk("t1_tvalid", {31'd0, cmd_tvalid}, 32'd1);
        chk("t1_tdata", {24'd0, cmd_tdata}, 32'h00);
        chk("t1_tlast", {31'd0, cmd_tlast}, 32'd0);
        cmd_tready = 1'b1; tick(); cmd_tready = 1'b0;
        chk("t1_drained", {31'd0, cmd_tvalid}, 32'd0);

        // AA, BB, LAST CC under backpressure
        send(32'h01AA_0000); send(32'h01BB_0000); send(32'h03CC_0000);
        repeat (10) tick();
        chk("t2_held_valid", {31'd0, cmd_tvalid}, 32'd1);
        cmd_tready = 1'b1;
        chk("t2_beat0", {23'd0, cmd_tlast, cmd_tdata}, 32'h0AA);
        tick();
        chk("t2_beat1", {23'd0, cmd_tlast, cmd_tdata}, 32'h0BB);
        tick();
        chk("t2_beat2", {23'd0, cmd_tlast, cmd_tdata}, 32'h1CC);
        tick();
        chk("t2_empty", {31'd0, cmd_tvalid}, 32'd0);
        cmd_tready = 1'b0;

        // 20 bytes into a 16-deep FIFO
        for (int i = 0; i < 20; i++) send(32'h0100_0000 | (i << 16));
        chk("t3_ovf_count", {16'd0, cmd_ovf}, {16'd0, exp_ovf});
        cmd_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_retained", {23'd0, cmd_tvalid, cmd_tdata}, 32'h100 | i);
            tick();
        end
        chk("t3_no_extra", {31'd0, cmd_tvalid}, 32'd0);
        cmd_tready = 1'b0;

        // firmware stream with in-band mark
        send(32'h0211_0000); send(32'h0002_0000); send(32'h0222_0000);
        chk("t4_mark_idle", {31'd0, fw_mark}, 32'd0);
        fw_tready = 1'b1;
        chk("t4_beat0", {23'd0, fw_tuser, fw_tdata}, 32'h011);
        tick();
        chk("t4_mark_not_yet", {31'd0, fw_mark}, 32'd0);
        chk("t4_beat1", {23'd0, fw_tuser, fw_tdata}, 32'h100);
        tick();
        chk("t4_mark_pulse", {31'd0, fw_mark}, 32'd1);
        chk("t4_beat2", {23'd0, fw_tuser, fw_tdata}, 32'h022);
        tick();
        chk("t4_mark_single", {31'd0, fw_mark}, 32'd0);
        chk("t4_fw_empty", {31'd0, fw_tvalid}, 32'd0);
        fw_tready = 1'b0;

        // SPECIAL 0x01 flushes mode1 only
        send(32'h0101_0000); send(32'h0102_0000); send(32'h0103_0000);
        send(32'h0233_0000);
        chk("t5_queued", {31'd0, cmd_tvalid}, 32'd1);
        chk("t5_rst_idle", {31'd0, cmdproc_rst}, 32'd0);
        send(32'h0001_0000);
        chk("t5_cmdproc_rst", {31'd0, cmdproc_rst}, 32'd1);
        chk("t5_flushed", {31'd0, cmd_tvalid}, 32'd0);
        chk("t5_fw_kept", {23'd0, fw_tvalid, fw_tdata}, 32'h133);
        chk("t5_ovf_kept", {16'd0, cmd_ovf}, {16'd0, exp_ovf});
        tick();
        chk("t5_rst_single", {31'd0, cmdproc_rst}, 32'd0);

        // run-control pulses on consecutive words
        command_valid = 1'b1;
        command = 32'h0400_0000; tick();
        chk("t6_dosync", {29'd0, rundosync, runrst, runstop}, 32'b100);
        command = 32'h0800_0000; tick();
        chk("t6_runrst", {29'd0, rundosync, runrst, runstop}, 32'b010);
        command = 32'h0C00_0000; tick();
        chk("t6_runstop", {29'd0, rundosync, runrst, runstop}, 32'b001);
        command = 32'h8400_0000; tick();
        chk("t6_not_msg", {29'd0, rundosync, runrst, runstop}, 32'b000);
        command_valid = 1'b0; command = 32'h0;

        // reset mid-stream
        send(32'h0144_0000); send(32'h0255_0000);
        chk("t7_pre_cmd", {23'd0, cmd_tvalid, cmd_tdata}, 32'h144);
        command = 32'h0555_8000; command_valid = 1'b1; rst = 1'b1;
        #1;
        chk("t7_trig_masked", {31'd0, trig_valid}, 32'd0);
        tick();
        chk("t7_cmd_cleared", {23'd0, cmd_tvalid, cmd_tdata}, 32'h000);
        chk("t7_fw_cleared", {22'd0, fw_tvalid, fw_tuser, fw_tdata}, 32'h000);
        chk("t7_pulses", {27'd0, rundosync, runrst, runstop, cmdproc_rst, fw_mark}, 32'd0);
        chk("t7_counters", {cmd_ovf, fw_ovf}, 32'd0);
        rst = 1'b0; command_valid = 1'b0; command = 32'h0;
        tick();
        chk("t7_still_empty", {30'd0, cmd_tvalid, fw_tvalid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
